vedic_mult_pipe: RTL

// - Parametrised, pipelined successor of the 8-bit Vedic multiplier with Brent-Kung adder.
// - Computes P = A x B for W-bit operands in three register stages.
// - Partial products come from the Urdhva-Tiryagbhyam split into four (W/2)x(W/2) sub-products, recursive down to a 2x2 base.
// - Partial-product sums use Brent-Kung prefix adders.
// - Valid/ready stream interface, so it can be dropped into datapaths with backpressure.

---
 rtl/vedic_mult_pipe.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined Vedic (Urdhva-Tiryagbhyam) multiplier with Brent-Kung adders and valid/ready flow.
// Optional two's-complement operands are enabled by defining VEDIC_SIGNED_EN (adds the sgn port).

module vedic_bk_add #(
    parameter int N  = 8,
    parameter int CO = 0
) (
    input  logic            cin,
    input  logic [N-1:0]    x,
    input  logic [N-1:0]    y,
    output logic [N+CO-1:0] sum
);
    // Prefix tree spans only the positions whose carries are consumed.
    localparam int M    = N - 1 + CO;
    localparam int L    = $clog2(M);
    localparam int NLVL = 2 * L - 1;

    logic [N-1:0] half_s;
    logic [M-1:0] g0_s;
    logic [M-1:0] gp_s;
    logic [M-1:0] pp_s;
    logic [M:0]   carry_s;

    assign half_s = x ^ y;
    assign g0_s   = x[M-1:0] & y[M-1:0];

    for (genvar k = 0; k < NLVL; k++) begin : lvl
        localparam int D    = (k < L) ? k : (NLVL - 1 - k);
        localparam int KP   = (k == 0) ? 0 : (k - 1);
        localparam int SPAN = 2 ** D;
        logic [M-1:0] gi_s;
        logic [M-1:0] pi_s;
        logic [M-1:0] go_s;
        logic [M-1:0] po_s;

        if (k == 0) begin : head
            assign gi_s = g0_s;
            assign pi_s = half_s[M-1:0];
        end else begin : chain
            assign gi_s = lvl[KP].go_s;
            assign pi_s = lvl[KP].po_s;
        end

        // Up-sweep combines at block ends; down-sweep fills the interior positions.
        for (genvar i = 0; i < M; i++) begin : node
            localparam bit UP_NODE = (k < L) && (((i + 1) % (2 * SPAN)) == 0);
            localparam bit DN_NODE = (k >= L) && (((i + 1) % (2 * SPAN)) == SPAN) && ((i + 1) > (2 * SPAN));
            if (UP_NODE || DN_NODE) begin : op
                assign go_s[i] = gi_s[i] | (pi_s[i] & gi_s[i-SPAN]);
                assign po_s[i] = pi_s[i] & pi_s[i-SPAN];
            end else begin : pass
                assign go_s[i] = gi_s[i];
                assign po_s[i] = pi_s[i];
            end
        end
    end

    assign gp_s       = lvl[NLVL-1].go_s;
    assign pp_s       = lvl[NLVL-1].po_s;
    assign carry_s    = {gp_s | (pp_s & {M{cin}}), cin};
    assign sum[N-1:0] = half_s ^ carry_s[N-1:0];

    if (CO != 0) begin : cout
        assign sum[N] = carry_s[M];
    end
endmodule

module vedic_combine #(
    parameter int N = 8
) (
    input  logic [N-1:0]   ll,
    input  logic [N-1:0]   lh,
    input  logic [N-1:0]   hl,
    input  logic [N-1:0]   hh,
    output logic [2*N-1:0] p
);
    localparam int H = N / 2;

    logic [N:0]     mid_s;
    logic [N+H-1:0] upper_s;

    vedic_bk_add #(.N(N), .CO(1)) u_mid (
        .cin (1'b0),
        .x   (lh),
        .y   (hl),
        .sum (mid_s)
    );

    // The low H bits of LL never see a carry, so only the upper part is summed.
    vedic_bk_add #(.N(N + H), .CO(0)) u_top (
        .cin (1'b0),
        .x   ({hh, ll[N-1:H]}),
        .y   ({{(H-1){1'b0}}, mid_s}),
        .sum (upper_s)
    );

    assign p = {upper_s, ll[H-1:0]};
endmodule

module vedic_mul #(
    parameter int N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    if (N == 2) begin : base
        logic c_s;
        assign c_s  = a[1] & b[0] & a[0] & b[1];
        assign p[0] = a[0] & b[0];
        assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
        assign p[2] = (a[1] & b[1]) ^ c_s;
        assign p[3] = (a[1] & b[1]) & c_s;
    end else begin : split
        localparam int H = N / 2;
        logic [N-1:0] ll_s;
        logic [N-1:0] lh_s;
        logic [N-1:0] hl_s;
        logic [N-1:0] hh_s;

        vedic_mul #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll_s));
        vedic_mul #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh_s));
        vedic_mul #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl_s));
        vedic_mul #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh_s));

        vedic_combine #(.N(N)) u_comb (
            .ll (ll_s),
            .lh (lh_s),
            .hl (hl_s),
            .hh (hh_s),
            .p  (p)
        );
    end
endmodule

module vedic_mult_pipe #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
`ifdef VEDIC_SIGNED_EN
    input  logic           sgn,
`endif
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p
);
    localparam int H = W / 2;

    logic           en1_s;
    logic           en2_s;
    logic           en3_s;
    logic           v1_r;
    logic           v2_r;
    logic           v3_r;
    logic [W-1:0]   a_mag_s;
    logic [W-1:0]   b_mag_s;
    logic [W-1:0]   a1_r;
    logic [W-1:0]   b1_r;
    logic [W-1:0]   ll_s;
    logic [W-1:0]   lh_s;
    logic [W-1:0]   hl_s;
    logic [W-1:0]   hh_s;
    logic [W-1:0]   ll_r;
    logic [W-1:0]   lh_r;
    logic [W-1:0]   hl_r;
    logic [W-1:0]   hh_r;
    logic [2*W-1:0] mag_prod_s;
    logic [2*W-1:0] prod_s;
    logic [2*W-1:0] p_r;

    // A stage advances when it is empty or the stage after it advances.
    assign en3_s     = !v3_r || out_ready;
    assign en2_s     = !v2_r || en3_s;
    assign en1_s     = !v1_r || en2_s;
    assign in_ready  = en1_s;
    assign out_valid = v3_r;
    assign p         = p_r;

`ifdef VEDIC_SIGNED_EN
    logic           neg_s;
    logic           neg1_r;
    logic           neg2_r;
    logic [2*W-1:0] neg_prod_s;

    // The most negative operand maps to magnitude 2^(W-1), which still fits in W bits.
    assign a_mag_s = (sgn && a[W-1]) ? ((~a) + {{(W-1){1'b0}}, 1'b1}) : a;
    assign b_mag_s = (sgn && b[W-1]) ? ((~b) + {{(W-1){1'b0}}, 1'b1}) : b;
    assign neg_s   = sgn && (a[W-1] ^ b[W-1]);

    // Result sign follows its operands through S1 and S2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg1_r <= 1'b0;
            neg2_r <= 1'b0;
        end else begin
            if (en1_s) neg1_r <= neg_s;
            if (en2_s) neg2_r <= neg1_r;
        end
    end

    vedic_bk_add #(.N(2 * W), .CO(0)) u_neg (
        .cin (1'b1),
        .x   (~mag_prod_s),
        .y   ({(2*W){1'b0}}),
        .sum (neg_prod_s)
    );

    assign prod_s = neg2_r ? neg_prod_s : mag_prod_s;
`else
    assign a_mag_s = a;
    assign b_mag_s = b;
    assign prod_s  = mag_prod_s;
`endif

    vedic_mul #(.N(H)) u_ll (.a(a1_r[H-1:0]), .b(b1_r[H-1:0]), .p(ll_s));
    vedic_mul #(.N(H)) u_lh (.a(a1_r[H-1:0]), .b(b1_r[W-1:H]), .p(lh_s));
    vedic_mul #(.N(H)) u_hl (.a(a1_r[W-1:H]), .b(b1_r[H-1:0]), .p(hl_s));
    vedic_mul #(.N(H)) u_hh (.a(a1_r[W-1:H]), .b(b1_r[W-1:H]), .p(hh_s));

    vedic_combine #(.N(W)) u_comb (
        .ll (ll_r),
        .lh (lh_r),
        .hl (hl_r),
        .hh (hh_r),
        .p  (mag_prod_s)
    );

    // Stage valid flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else begin
            if (en1_s) v1_r <= in_valid;
            if (en2_s) v2_r <= v1_r;
            if (en3_s) v3_r <= v2_r;
        end
    end

    // Stage data registers; each holds while its stage is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a1_r <= {W{1'b0}};
            b1_r <= {W{1'b0}};
            ll_r <= {W{1'b0}};
            lh_r <= {W{1'b0}};
            hl_r <= {W{1'b0}};
            hh_r <= {W{1'b0}};
            p_r  <= {(2*W){1'b0}};
        end else begin
            if (en1_s) begin
                a1_r <= a_mag_s;
                b1_r <= b_mag_s;
            end
            if (en2_s) begin
                ll_r <= ll_s;
                lh_r <= lh_s;
                hl_r <= hl_s;
                hh_r <= hh_s;
            end
            if (en3_s) begin
                p_r <= prod_s;
            end
        end
    end
endmodule
